// File: rtl/scan_sequencer.sv
// scan_sequencer
//   Sequential address generator for a downstream N-bit decoder. Steps a
//   select through 0..2^N-1, holding each value for dwell+1 cycles, in
//   single-pass or continuous mode, with start/stop control and status pulses.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : start request, accepted only in IDLE when stop is low
//   stop   : abort request, returns to IDLE on the next edge
//   mode   : 0 = single pass, 1 = continuous (latched on accepted start)
//   dwell  : extra hold cycles per slot (latched on accepted start)
//   sel    : current slot index (decoder a)
//   sel_en : slot valid (decoder enable), identical to busy
//   busy   : high while scanning
//   done   : one-cycle pulse after a single pass completes
//   wrap   : one-cycle pulse on the first cycle of slot 0 after a wrap
module scan_sequencer #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N-1:0]       sel,
  output logic               sel_en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = SCAN;
          mode_d  = mode;
          dwell_d = dwell;
          sel_d   = '0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        // stop outranks slot advance, wrap and completion
        if (stop) begin
          state_d = IDLE;
          sel_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (sel_q == '1) begin
            sel_d = '0;
            if (mode_q) begin
              wrap_d = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            sel_d = sel_q + N'(1);
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel    = sel_q;
  assign sel_en = busy_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

  localparam int N       = 3;
  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       sel;
  logic               sel_en;
  logic               busy;
  logic               done;
  logic               wrap;

  int unsigned n_checks;
  int unsigned n_fail;

  scan_sequencer #(
    .N       (N),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .dwell  (dwell),
    .sel    (sel),
    .sel_en (sel_en),
    .busy   (busy),
    .done   (done),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are then stable until the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dec_y();
    logic [7:0] y;
    y = 8'h00;
    if (sel_en) y[sel] = 1'b1;
    return y;
  endfunction

  logic [7:0] exp_y [8];
  int unsigned wraps;

  initial begin
    exp_y[0] = 8'b0000_0001; exp_y[1] = 8'b0000_0010;
    exp_y[2] = 8'b0000_0100; exp_y[3] = 8'b0000_1000;
    exp_y[4] = 8'b0001_0000; exp_y[5] = 8'b0010_0000;
    exp_y[6] = 8'b0100_0000; exp_y[7] = 8'b1000_0000;

    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    dwell = '0;
    tick();
    check_eq("rst_sel",    32'(sel),    0);
    check_eq("rst_sel_en", 32'(sel_en), 0);
    check_eq("rst_busy",   32'(busy),   0);
    check_eq("rst_done",   32'(done),   0);
    check_eq("rst_wrap",   32'(wrap),   0);
    rst = 1'b0;
    tick();

    // single pass, dwell 0
    start = 1'b1; mode = 1'b0; dwell = 8'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("sp_sel",    32'(sel),    32'(i));
      check_eq("sp_sel_en", 32'(sel_en), 1);
      check_eq("sp_busy",   32'(busy),   1);
      check_eq("sp_done",   32'(done),   0);
      tick();
    end
    check_eq("sp_done_pulse", 32'(done),   1);
    check_eq("sp_end_busy",   32'(busy),   0);
    check_eq("sp_end_sel",    32'(sel),    0);
    check_eq("sp_end_sel_en", 32'(sel_en), 0);
    tick();
    check_eq("sp_done_clear", 32'(done), 0);

    // dwell 2: 3 cycles per slot; mid-scan dwell change and start are ignored
    start = 1'b1; dwell = 8'd2;
    tick();
    start = 1'b0;
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 3; k++) begin
        check_eq("dw_sel",  32'(sel),  32'(s));
        check_eq("dw_busy", 32'(busy), 1);
        check_eq("dw_done", 32'(done), 0);
        if (s == 3 && k == 0) begin
          dwell = 8'd5;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick();
      end
    end
    start = 1'b0;
    check_eq("dw_done_pulse", 32'(done), 1);
    check_eq("dw_end_busy",   32'(busy), 0);
    tick();

    // continuous, dwell 1: 3 wraps over 4 passes, never done
    start = 1'b1; mode = 1'b1; dwell = 8'd1;
    tick();
    start = 1'b0; mode = 1'b0;
    wraps = 0;
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 8; s++) begin
        for (int k = 0; k < 2; k++) begin
          check_eq("ct_sel",  32'(sel),  32'(s));
          check_eq("ct_wrap", 32'(wrap), (p > 0 && s == 0 && k == 0) ? 1 : 0);
          check_eq("ct_done", 32'(done), 0);
          check_eq("ct_busy", 32'(busy), 1);
          if (wrap) wraps++;
          tick();
        end
      end
    end
    check_eq("ct_wrap_count", wraps, 3);
    check_eq("ct_wrap4", 32'(wrap), 1);

    // stop at sel=4 in the fifth pass
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 2; k++) tick();
    end
    check_eq("st_sel_pre", 32'(sel), 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("st_busy",   32'(busy),   0);
    check_eq("st_sel_en", 32'(sel_en), 0);
    check_eq("st_sel",    32'(sel),    0);
    check_eq("st_done",   32'(done),   0);
    check_eq("st_wrap",   32'(wrap),   0);
    tick();
    check_eq("st_done2",  32'(done),   0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; mode = 1'b0; dwell = 8'd0;
    tick();
    start = 1'b0; stop = 1'b0;
    check_eq("ss_busy", 32'(busy), 0);
    tick();
    check_eq("ss_busy2", 32'(busy), 0);

    // decoder view, single pass, back-to-back start on the done cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("dec_y", 32'(dec_y()), 32'(exp_y[i]));
      tick();
    end
    check_eq("dec_done", 32'(done), 1);
    check_eq("dec_y_off", 32'(dec_y()), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("b2b_busy", 32'(busy), 1);
    check_eq("b2b_y0",   32'(dec_y()), 32'(exp_y[0]));
    tick();
    tick();
    check_eq("b2b_sel2", 32'(sel), 2);

    // asynchronous reset mid-scan, checked before any clock edge
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_sel",    32'(sel),    0);
    check_eq("arst_sel_en", 32'(sel_en), 0);
    check_eq("arst_busy",   32'(busy),   0);
    check_eq("arst_done",   32'(done),   0);
    check_eq("arst_wrap",   32'(wrap),   0);
    rst = 1'b0;
    tick();
    check_eq("arst_done_after", 32'(done), 0);
    check_eq("arst_busy_after", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Sequential address generator that sits directly upstream of decoder_Nbit.
- Steps an N-bit select through 0..2^N-1 and drives the decoder's a/enable inputs (sel -> a, sel_en -> enable).
- Each select value is held for a programmable dwell time.
- Used for row/column scanning (LED matrix, keypad strobe). Supports single-pass and continuous modes, with a start/stop handshake and status pulses.

Parameters:
- N, 3, select width; must match the downstream decoder's N. Scan covers 2^N slots.
- DWELL_W, 8, width of the dwell input.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous active-high reset.
- start  input  1  start request; sampled only in IDLE.
- stop  input  1  abort request; sampled every cycle.
- mode  input  1  0 = single pass, 1 = continuous; latched on accepted start.
- dwell  input  DWELL_W  extra hold cycles per slot; latched on accepted start.
- sel  output  N  current slot index, to decoder a.
- sel_en  output  1  slot valid, to decoder enable.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse after a single pass completes.
- wrap  output  1  one-cycle pulse on the first cycle of slot 0 after a continuous-mode wrap.

Behaviour:
- Reset is asynchronous on rst high, and all outputs are registered. Reset values:
  - state = IDLE
  - sel = 0, sel_en = 0, busy = 0, done = 0, wrap = 0
  - dwell counter = 0; latched mode and dwell = 0
- States: IDLE, SCAN.
- IDLE:
  - start=1 and stop=0: on the next edge, latch mode and dwell, enter SCAN with sel=0, sel_en=1, busy=1, dwell counter=0.
  - start=1 and stop=1 in the same cycle: stop wins and the block stays IDLE.
  - done is low in IDLE except for its one-cycle pulse.
- SCAN timing:
  - Slot length is dwell_lat+1 cycles; dwell=0 gives 1 cycle per slot, and dwell=2^DWELL_W-1 gives 2^DWELL_W cycles.
  - The counter increments each cycle. When counter == dwell_lat, the slot ends: the counter clears, and sel advances at the next edge.
- End of slot 2^N-1:
  - mode_lat=0: next edge enters IDLE with sel=0, sel_en=0, busy=0, done=1 for exactly one cycle.
  - mode_lat=1: sel wraps to 0 and wrap=1 for that first cycle of slot 0. This repeats indefinitely until stop or reset.
- stop:
  - stop=1 in SCAN: next edge enters IDLE with sel=0, sel_en=0, busy=0, counter=0.
  - No done or wrap pulse is generated.
  - stop has priority over slot advance, wrap and completion in the same cycle.
- start while busy is ignored; it causes no restart and no re-latch.
- Changes to mode or dwell during SCAN have no effect until the next accepted start.
- Back-to-back operation: start asserted in the same cycle that done is high is accepted, because the block is in IDLE. SCAN begins on the next edge.
- sel changes only at slot boundaries, so the downstream one-hot output is glitch-free per cycle.
- sel_en == busy at all times.
- Reset mid-scan returns all outputs to reset values immediately (asynchronous), with no done pulse.
- Single-pass total busy time: 2^N × (dwell_lat+1) cycles.

Test Plan:
- Reset: assert rst mid-simulation -> sel=0, sel_en=0, busy=0, done=0, wrap=0 immediately, without waiting for a clock edge.
- Single pass, N=3, dwell=0, mode=0, one-cycle start pulse:
  - sel = 0,1,...,7 on consecutive cycles with sel_en=1.
  - busy high for exactly 8 cycles.
  - done=1 for one cycle immediately after sel=7; then sel=0, sel_en=0.
- Dwell hold, dwell=2, mode=0:
  - Each sel value is held for 3 cycles; busy is high for 24 cycles.
  - Change dwell to 5 at sel=3 -> hold stays 3 cycles.
  - Assert start again mid-scan -> ignored.
- Continuous, dwell=1, mode=1:
  - Each sel is held for 2 cycles; after sel=7, sel=0 with wrap=1 for one cycle.
  - Check 3 wraps; done never asserts.
- Stop:
  - Assert stop for one cycle while sel=4 -> next cycle IDLE, sel_en=0, busy=0, no done.
  - start and stop together in IDLE -> remains IDLE.
- Chained with decoder_Nbit (N=3), single pass, dwell=0:
  - Decoder y = 00000001, 00000010, ..., 10000000 on successive cycles.
  - y = 00000000 whenever sel_en=0.
  - Assert start on the done cycle -> new scan starts the next cycle.
